// File: rtl/bidir_barrel_shift_pipe_pkg.sv
// Shared definitions for the pipelined bidirectional barrel shifter:
// operation mode encodings and the log2 helper used to size amount and stage count.
package bbs_pkg;

    typedef enum logic [1:0] {
        MODE_ROT = 2'b00,
        MODE_LSH = 2'b01,
        MODE_ASH = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

    // Smallest n with 2**n >= value; exact log2 for the power-of-two widths used here.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bidir_barrel_shift_pipe_stage.sv
// One registered barrel-shifter stage: conditionally shifts/rotates by 2**K when amt bit K is set.
// Optional flags (BARREL_SHIFT_FLAGS_EN) add a running carry-out and a zero flag.
module bbs_stage
    import bbs_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int K     = 0,
    localparam int SHW   = log2(WIDTH),
    localparam int S     = 1 << K
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  logic [SHW-1:0]   prev_amt,
    input  logic             prev_left,
    input  logic [1:0]       prev_mode,
`ifdef BARREL_SHIFT_FLAGS_EN
    input  logic             prev_cout,
    output logic             zero,
    output logic             cout,
`endif
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [SHW-1:0]   amt,
    output logic             left,
    output logic [1:0]       mode
);

    // Arithmetic right fills from the current MSB; earlier stages already replicated the
    // original sign there, so no separate sign bit has to travel down the pipe.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d,
                                              input logic             to_left,
                                              input logic [1:0]       m);
        logic [WIDTH-1:0] r;
        case (m)
            MODE_LSH: r = to_left ? (d << S) : (d >> S);
            MODE_ASH: r = to_left ? (d << S) : WIDTH'($signed(d) >>> S);
            default:  r = to_left ? ((d << S) | (d >> (WIDTH - S)))
                                  : ((d >> S) | (d << (WIDTH - S)));
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] next_data;

    always_comb begin
        next_data = prev_data;
        if (prev_amt[K]) next_data = step(prev_data, prev_left, prev_mode);
    end

`ifdef BARREL_SHIFT_FLAGS_EN
    // The last bit to leave is the edge bit of whichever active stage shifts last.
    function automatic logic lost_bit(input logic [WIDTH-1:0] d, input logic to_left);
        return to_left ? d[WIDTH-S] : d[S-1];
    endfunction

    logic next_cout;

    always_comb begin
        next_cout = prev_cout;
        if (prev_amt[K]) next_cout = lost_bit(prev_data, prev_left);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cout <= 1'b0;
            zero <= 1'b0;
        end else if (advance) begin
            cout <= next_cout;
            zero <= (next_data == '0);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            amt   <= '0;
            left  <= 1'b0;
            mode  <= MODE_ROT;
        end else if (advance) begin
            valid <= prev_valid;
            data  <= next_data;
            amt   <= prev_amt;
            left  <= prev_left;
            mode  <= prev_mode;
        end
    end

endmodule

// File: rtl/bidir_barrel_shift_pipe.sv
// Pipelined bidirectional barrel shifter: log2(WIDTH) stages, one word per cycle, global stall.
// Define BARREL_SHIFT_FLAGS_EN to add the out_zero / out_cout result flags.
module bidir_barrel_shift_pipe
    import bbs_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = log2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic             in_left,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef BARREL_SHIFT_FLAGS_EN
   ,output logic             out_zero,
    output logic             out_cout
`endif
);

    // Every stage moves in lockstep; a held output freezes the whole pipe, bubbles included.
    logic advance;

    logic             valid_p [0:SHW];
    logic [WIDTH-1:0] data_p  [0:SHW];
    logic [SHW-1:0]   amt_p   [0:SHW];
    logic             left_p  [0:SHW];
    logic [1:0]       mode_p  [0:SHW];

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign valid_p[0] = in_valid;
    assign data_p[0]  = in_data;
    assign amt_p[0]   = in_amt;
    assign left_p[0]  = in_left;
    assign mode_p[0]  = in_mode;

`ifdef BARREL_SHIFT_FLAGS_EN
    logic cout_p [0:SHW];
    logic zero_p [1:SHW];

    assign cout_p[0] = 1'b0;
    assign out_cout  = cout_p[SHW];
    assign out_zero  = zero_p[SHW];
`endif

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        bbs_stage #(
            .WIDTH (WIDTH),
            .K     (k)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .advance    (advance),
            .prev_valid (valid_p[k]),
            .prev_data  (data_p[k]),
            .prev_amt   (amt_p[k]),
            .prev_left  (left_p[k]),
            .prev_mode  (mode_p[k]),
`ifdef BARREL_SHIFT_FLAGS_EN
            .prev_cout  (cout_p[k]),
            .zero       (zero_p[k+1]),
            .cout       (cout_p[k+1]),
`endif
            .valid      (valid_p[k+1]),
            .data       (data_p[k+1]),
            .amt        (amt_p[k+1]),
            .left       (left_p[k+1]),
            .mode       (mode_p[k+1])
        );
    end

    assign out_valid = valid_p[SHW];
    assign out_data  = data_p[SHW];

endmodule

// File: tb/tb_bidir_barrel_shift_pipe.sv
// Self-checking bench for bidir_barrel_shift_pipe (WIDTH = 8): bit-by-bit reference model,
// per-cycle compare process and directed vectors with literal expectations.
module tb_bidir_barrel_shift_pipe;
    import bbs_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [2:0]       in_amt = '0;
    logic             in_left = 1'b0;
    logic [1:0]       in_mode = 2'b00;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
`ifdef BARREL_SHIFT_FLAGS_EN
    logic             out_zero;
    logic             out_cout;
`endif

    bidir_barrel_shift_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_left   (in_left),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef BARREL_SHIFT_FLAGS_EN
       ,.out_zero  (out_zero),
        .out_cout  (out_cout)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int outputs_seen = 0;

    logic [7:0] lit_data = '0;
    bit         lit_on = 1'b0;
    logic [8:0] pin;

    typedef struct {
        logic [7:0] data;
        logic       cout;
        logic [7:0] lit;
        bit         has_lit;
    } item_t;

    item_t expect_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: apply the operation one bit position at a time; returns {last bit out, result}.
    function automatic logic [8:0] model(input logic [7:0] d, input int amt,
                                         input logic to_left, input logic [1:0] mode);
        logic [7:0] r;
        logic       fill;
        logic       lost;
        r = d;
        fill = 1'b0;
        lost = 1'b0;
        for (int i = 0; i < amt; i++) begin
            if (to_left) begin
                lost = r[7];
                fill = (mode == MODE_LSH || mode == MODE_ASH) ? 1'b0 : r[7];
                r = {r[6:0], fill};
            end else begin
                lost = r[0];
                if (mode == MODE_LSH)      fill = 1'b0;
                else if (mode == MODE_ASH) fill = d[7];
                else                       fill = r[0];
                r = {fill, r[7:1]};
            end
        end
        return {lost, r};
    endfunction

    // Compare process: inputs and outputs are both stable at the falling edge.
    bit         was_stalled = 1'b0;
    logic [7:0] held_data = '0;
    item_t      mon_item;
    logic [8:0] mon_model;

    always @(negedge clk) begin
        if (rst) begin
            expect_q.delete();
            check("reset out_valid", out_valid, 0);
            check("reset out_data", out_data, 0);
            check("reset in_ready", in_ready, 1);
`ifdef BARREL_SHIFT_FLAGS_EN
            check("reset out_zero", out_zero, 0);
            check("reset out_cout", out_cout, 0);
`endif
            was_stalled = 1'b0;
        end else begin
            check("in_ready vs advance", in_ready, !out_valid || out_ready);
            if (was_stalled) begin
                check("stall out_valid held", out_valid, 1);
                check("stall out_data held", out_data, held_data);
            end
            if (out_valid && out_ready) begin
                outputs_seen++;
                if (expect_q.size() == 0) begin
                    check("unexpected output", out_valid, 0);
                end else begin
                    mon_item = expect_q.pop_front();
                    check("out_data vs model", out_data, mon_item.data);
                    if (mon_item.has_lit) check("out_data vs literal", out_data, mon_item.lit);
`ifdef BARREL_SHIFT_FLAGS_EN
                    check("out_zero vs model", out_zero, mon_item.data == 8'h00);
                    check("out_cout vs model", out_cout, mon_item.cout);
`endif
                end
            end
            if (in_valid && in_ready) begin
                mon_model = model(in_data, int'(in_amt), in_left, in_mode);
                mon_item.data = mon_model[7:0];
                mon_item.cout = mon_model[8];
                mon_item.lit = lit_data;
                mon_item.has_lit = lit_on;
                expect_q.push_back(mon_item);
            end
            was_stalled = out_valid && !out_ready;
            held_data = out_data;
        end
    end

    task automatic send(input logic [7:0] d, input int amt, input logic to_left,
                        input logic [1:0] mode, input logic [7:0] lit, input bit has_lit);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_data = d;
        in_amt = amt[2:0];
        in_left = to_left;
        in_mode = mode;
        lit_data = lit;
        lit_on = has_lit;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("send handshake timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lit_on = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expect_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain queue empty", expect_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic stall_after_first();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("first stalled-test result", out_valid, 1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("in_ready low while stalled", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
    endtask

    task automatic ready_pattern();
        for (int i = 0; i < 90; i++) begin
            @(posedge clk);
            #1 out_ready = (i % 3) != 0;
        end
        out_ready = 1'b1;
    endtask

    task automatic sweep();
        for (int m = 0; m < 4; m++)
            for (int l = 0; l < 2; l++)
                for (int a = 0; a < 8; a++)
                    send(8'hA5 ^ 8'(a * 17 + m), a, l[0], m[1:0], 8'h00, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        pin = model(8'h81, 1, 1'b1, MODE_ROT);  check("model rol 81/1", pin[7:0], 8'h03);
        pin = model(8'hB4, 3, 1'b0, MODE_ROT);  check("model ror B4/3", pin[7:0], 8'h96);
        pin = model(8'h90, 2, 1'b0, MODE_LSH);  check("model lsr 90/2", pin[7:0], 8'h24);
        pin = model(8'h90, 2, 1'b0, MODE_ASH);  check("model asr 90/2", pin[7:0], 8'hE4);
        pin = model(8'h90, 7, 1'b0, MODE_ASH);  check("model asr 90/7", pin[7:0], 8'hFF);
        pin = model(8'h80, 1, 1'b1, MODE_LSH);  check("model lsl 80/1 cout", pin, 9'h100);
        pin = model(8'hA5, 0, 1'b0, MODE_ROT);  check("model rot amt0", pin, 9'h0A5);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("post-reset out_valid", out_valid, 0);
        check("post-reset in_ready", in_ready, 1);

        // Latency: result visible in the third cycle after the word is presented.
        send(8'h81, 1, 1'b1, MODE_ROT, 8'h03, 1'b1);
        check("latency cycle1 out_valid", out_valid, 0);
        @(posedge clk); #1;
        check("latency cycle2 out_valid", out_valid, 0);
        @(posedge clk); #1;
        check("latency cycle3 out_valid", out_valid, 1);
        check("latency cycle3 out_data", out_data, 8'h03);
        drain();

        send(8'hB4, 3, 1'b0, MODE_ROT, 8'h96, 1'b1);
        send(8'h90, 2, 1'b0, MODE_LSH, 8'h24, 1'b1);
        send(8'h90, 2, 1'b0, MODE_ASH, 8'hE4, 1'b1);
        send(8'h90, 7, 1'b0, MODE_ASH, 8'hFF, 1'b1);
        send(8'h81, 1, 1'b1, MODE_RSV, 8'h03, 1'b1);
        send(8'h0F, 7, 1'b1, MODE_LSH, 8'h80, 1'b1);
        send(8'h81, 1, 1'b1, MODE_ASH, 8'h02, 1'b1);
        send(8'h81, 7, 1'b1, MODE_ROT, 8'hC0, 1'b1);
        send(8'h70, 7, 1'b0, MODE_ASH, 8'h00, 1'b1);
        drain();

        fork
            sweep();
            ready_pattern();
        join
        out_ready = 1'b1;
        drain();

        outputs_seen = 0;
        fork
            begin
                for (int i = 1; i <= 4; i++) send(8'(i), 1, 1'b1, MODE_ROT, 8'(2 * i), 1'b1);
            end
            stall_after_first();
        join
        drain();
        check("stall test output count", outputs_seen, 4);

        // Reset with a result on the output and two words still in the stages.
        send(8'h11, 1, 1'b1, MODE_ROT, 8'h22, 1'b1);
        send(8'h33, 1, 1'b1, MODE_ROT, 8'h66, 1'b1);
        send(8'h44, 1, 1'b1, MODE_ROT, 8'h88, 1'b1);
        check("pre-reset out_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("async reset out_valid", out_valid, 0);
        check("async reset out_data", out_data, 0);
        check("async reset in_ready", in_ready, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("no stale output after reset", out_valid, 0);
        end
        @(posedge clk); #1;
        send(8'hF0, 4, 1'b0, MODE_ROT, 8'h0F, 1'b1);
        drain();

`ifdef BARREL_SHIFT_FLAGS_EN
        send(8'h80, 1, 1'b1, MODE_LSH, 8'h00, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("flags lsl out_valid", out_valid, 1);
        check("flags lsl out_zero", out_zero, 1);
        check("flags lsl out_cout", out_cout, 1);
        drain();
        send(8'hFF, 0, 1'b1, MODE_ROT, 8'hFF, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("flags rot0 out_valid", out_valid, 1);
        check("flags rot0 out_cout", out_cout, 0);
        check("flags rot0 out_zero", out_zero, 0);
        drain();
`endif

        check("expectations left over", expect_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bidir_barrel_shift_pipe.md
BIDIR_BARREL_SHIFT_PIPE -- requirements
Module: bidir_barrel_shift_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width; power of two, 4..64.
REQ-002 SHALL derive localparam SHW = log2(WIDTH), default 3, used as shift-amount width and stage count.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  input word offered.
REQ-006 SHALL have port in_ready  output  1  input word accepted when in_valid and in_ready are both high at a clock edge.
REQ-007 SHALL have port in_data  input  WIDTH  operand.
REQ-008 SHALL have port in_amt  input  SHW  shift/rotate distance.
REQ-009 SHALL have port in_left  input  1  1 = left, 0 = right.
REQ-010 SHALL have port in_mode  input  2  00 rotate, 01 logical shift, 10 arithmetic shift, 11 reserved.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port out_data  output  WIDTH  result.

Function
REQ-014 SHALL implement SHW pipeline stages; stage k applies a conditional shift/rotate by 2^k selected by amt bit k, then registers data, remaining controls and a valid bit.
REQ-015 SHALL produce out_valid exactly SHW cycles after acceptance when out_ready stays high; throughput one word per cycle.
REQ-016 SHALL advance all stages together when advance = !out_valid || out_ready; in_ready SHALL equal advance (combinational, no dependence on in_valid).
REQ-017 SHALL hold out_data, out_valid and every stage register unchanged while advance is low; no word lost, duplicated or reordered.
REQ-018 SHALL carry bubbles (valid = 0) through stages; bubbles are not collapsed.
REQ-019 Rotate: bits leaving one end SHALL enter the other end; amt = 0 returns data unchanged.
REQ-020 Logical shift: vacated positions SHALL fill with 0.
REQ-021 Arithmetic shift right SHALL fill with the original MSB; arithmetic shift left SHALL behave as logical shift left.
REQ-022 Mode 11 SHALL behave as rotate.
REQ-023 Maximum amt (WIDTH-1) SHALL be legal in all modes; no amount is clipped or wrapped.
REQ-024 out_data SHALL be held stable while out_valid is high and out_ready is low.

Reset
REQ-025 While rst is high, all stage valid bits, out_valid and out_data SHALL be 0 immediately, independent of clk.
REQ-026 in_ready SHALL be 1 during and after reset, since out_valid = 0.
REQ-027 Words in flight at reset assertion SHALL be discarded; the first accepted word after release SHALL emerge after SHW cycles.

Configuration
REQ-028 Macro BARREL_SHIFT_FLAGS_EN SHALL, when defined, add outputs out_zero (1 bit, out_data == 0) and out_cout (1 bit, last bit shifted or rotated out; 0 when amt = 0), both registered alongside out_data and reset to 0.
REQ-029 Without BARREL_SHIFT_FLAGS_EN these ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 Shared package bbs_pkg SHALL hold the mode encodings (MODE_ROT, MODE_LSH, MODE_ASH, MODE_RSV) and the log2 helper function.
REQ-031 One sub-module, bbs_stage, SHALL implement a single registered 2^k stage with parameters WIDTH and K; the top SHALL instantiate SHW copies of it.

Verification (WIDTH = 8, latency 3)
REQ-032 Rotate left, 8'h81, amt 1, out_ready high -> out_data 8'h03, out_valid high 3 cycles after acceptance.
REQ-033 Rotate right 8'hB4, amt 3 -> 8'h96; logical right 8'h90, amt 2 -> 8'h24; arithmetic right 8'h90, amt 2 -> 8'hE4; arithmetic right 8'h90, amt 7 -> 8'hFF.
REQ-034 Back-to-back inputs 8'h01..8'h04 (rotate left, amt 1), out_ready low for 5 cycles after the first result -> in_ready low while stalled; results 02, 04, 06, 08 arrive in order, each exactly once, with out_data stable during the stall.
REQ-035 Assert rst for 1 cycle with 2 words in flight -> out_valid 0 at once, no stale output afterward; next word (8'hF0, rotate right, amt 4) -> 8'h0F.
REQ-036 With BARREL_SHIFT_FLAGS_EN: logical left 8'h80, amt 1 -> out_data 8'h00, out_zero 1, out_cout 1; rotate, amt 0 -> out_cout 0.
